// File: rtl/servant_busmux_pkg.sv
// -----------------------------------------------------------------------------
// servant_busmux_pkg
// Shared types and helpers for the servant data-bus demultiplexer:
//   - state_e          : transaction FSM states (IDLE / WAIT / RESP)
//   - ERR_DATA_DEFAULT : read data returned on a bus error
//   - decode_t         : slave index plus valid flag
//   - decode_adr()     : extracts the slave-select field from an address
// -----------------------------------------------------------------------------
package servant_busmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Slave index is at most 4 bits wide (up to 16 slaves).
    typedef struct packed {
        logic [3:0] idx;
        logic       valid;
    } decode_t;

    // Select field is adr[sel_msb -: sel_w]; any index at or above
    // num_slaves is an unmapped region and decodes as invalid.
    function automatic decode_t decode_adr(
        input logic [31:0] adr,
        input int          sel_msb,
        input int          sel_w,
        input int          num_slaves
    );
        logic [31:0] field;
        decode_t     d;
        field   = (adr >> (sel_msb + 1 - sel_w)) & ((32'd1 << sel_w) - 32'd1);
        d.idx   = 4'(field);
        d.valid = (field < 32'(num_slaves));
        return d;
    endfunction

endpackage

// File: rtl/servant_busmux.sv
// -----------------------------------------------------------------------------
// servant_busmux
// Routes one Wishbone master (serv dbus) to NUM_SLAVES slaves selected by the
// address field adr[SEL_MSB -: clog2(NUM_SLAVES)]. Slaves flagged in ACK_MASK
// return their own ack (with an optional timeout); the others are acked by
// the mux one cycle after the request. Unmapped decodes and timeouts return
// ERR_DATA and raise a sticky error with the faulting address.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cpu_adr/dat/sel/we/cyc  master request
//   o_wb_cpu_rdt, o_wb_cpu_ack   registered master response
//   o_wb_s_adr/dat/sel/we        broadcast copies of the master request
//   o_wb_s_cyc                   one-hot per-slave request
//   i_wb_s_rdt, i_wb_s_ack       slave responses (slave k at [32k+31:32k])
//   o_err, o_err_adr, i_err_clr  sticky bus error, captured address, clear
// -----------------------------------------------------------------------------
module servant_busmux
    import servant_busmux_pkg::*;
#(
    parameter int unsigned           NUM_SLAVES = 4,
    parameter int unsigned           SEL_MSB    = 31,
    parameter logic [NUM_SLAVES-1:0] ACK_MASK   = '0,
    parameter int unsigned           TIMEOUT    = 255,
    parameter logic [31:0]           ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [31:0]                i_wb_cpu_adr,
    input  logic [31:0]                i_wb_cpu_dat,
    input  logic [3:0]                 i_wb_cpu_sel,
    input  logic                       i_wb_cpu_we,
    input  logic                       i_wb_cpu_cyc,
    output logic [31:0]                o_wb_cpu_rdt,
    output logic                       o_wb_cpu_ack,
    output logic [31:0]                o_wb_s_adr,
    output logic [31:0]                o_wb_s_dat,
    output logic [3:0]                 o_wb_s_sel,
    output logic                       o_wb_s_we,
    output logic [NUM_SLAVES-1:0]      o_wb_s_cyc,
    input  logic [32*NUM_SLAVES-1:0]   i_wb_s_rdt,
    input  logic [NUM_SLAVES-1:0]      i_wb_s_ack,
    output logic                       o_err,
    output logic [31:0]                o_err_adr,
    input  logic                       i_err_clr
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    // With the timeout disabled the counter is unused but kept 1 bit wide.
    localparam int CNT_W = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 32'd0) ? '0 : CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdt_q, rdt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic              we_q, we_d;
    logic              err_q;
    logic [31:0]       err_adr_q;
    logic              err_set_s;

    decode_t           dec_s;
    logic [3:0]        cur_idx_s;
    logic [31:0]       slave_rdt_s;
    logic              slave_ack_s;
    logic              slave_ackable_s;
    logic [NUM_SLAVES-1:0] s_cyc_s;

    assign dec_s = decode_adr(i_wb_cpu_adr, SEL_MSB, SEL_W, NUM_SLAVES);

    // In IDLE the live decode selects the slave; afterwards the latched index.
    assign cur_idx_s = (state_q == ST_WAIT) ? idx_q : dec_s.idx;

    // AND-OR mux of the selected slave's read data, ack and ack capability.
    // Acks from slaves the mux acks itself are masked off here.
    always_comb begin
        slave_rdt_s     = 32'h0;
        slave_ack_s     = 1'b0;
        slave_ackable_s = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            slave_rdt_s     = slave_rdt_s | (i_wb_s_rdt[32*k +: 32] & {32{cur_idx_s == 4'(k)}});
            slave_ack_s     = slave_ack_s | (i_wb_s_ack[k] & ACK_MASK[k] & (cur_idx_s == 4'(k)));
            slave_ackable_s = slave_ackable_s | (ACK_MASK[k] & (cur_idx_s == 4'(k)));
        end
    end

    // Per-slave request: combinational in IDLE, held in WAIT, never during reset.
    always_comb begin
        s_cyc_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            s_cyc_s[k] = ~i_rst & (cur_idx_s == 4'(k)) &
                         (((state_q == ST_IDLE) & i_wb_cpu_cyc & dec_s.valid) |
                          (state_q == ST_WAIT));
        end
    end

    // Next-state and response logic of the transaction FSM.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        rdt_d     = rdt_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        err_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cpu_cyc) begin
                    idx_d = dec_s.idx;
                    we_d  = i_wb_cpu_we;
                    cnt_d = '0;
                    if (!dec_s.valid) begin
                        rdt_d     = ERR_DATA;
                        err_set_s = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = ST_RESP;
                    end else if (!slave_ackable_s || slave_ack_s) begin
                        // Writes never return slave data.
                        rdt_d   = i_wb_cpu_we ? 32'h0 : slave_rdt_s;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (slave_ack_s) begin
                    rdt_d   = we_q ? 32'h0 : slave_rdt_s;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if ((TIMEOUT != 32'd0) && (cnt_q == CNT_LAST)) begin
                    rdt_d     = ERR_DATA;
                    err_set_s = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    // Saturate so a disabled timeout cannot wrap the counter.
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction state, counter and registered master response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdt_q   <= 32'h0;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
        end
    end

    // Sticky error flag and address; a new error beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q     <= 1'b0;
            err_adr_q <= 32'h0;
        end else if (err_set_s) begin
            err_q     <= 1'b1;
            err_adr_q <= i_wb_cpu_adr;
        end else if (i_err_clr) begin
            err_q     <= 1'b0;
        end
    end

    assign o_wb_cpu_ack = ack_q;
    assign o_wb_cpu_rdt = rdt_q;
    assign o_wb_s_adr   = i_wb_cpu_adr;
    assign o_wb_s_dat   = i_wb_cpu_dat;
    assign o_wb_s_sel   = i_wb_cpu_sel;
    assign o_wb_s_we    = i_wb_cpu_we;
    assign o_wb_s_cyc   = s_cyc_s;
    assign o_err        = err_q;
    assign o_err_adr    = err_adr_q;

endmodule

// File: tb/tb_servant_busmux.sv
// -----------------------------------------------------------------------------
// tb_servant_busmux
// Self-checking bench for servant_busmux configured with three slaves:
// slave 0 acks itself (timeout 8), slaves 1 and 2 are acked by the mux, and
// select value 3 is unmapped. Expected responses come from a transaction-level
// model: latency, read data and error outcome per request.
// -----------------------------------------------------------------------------
module tb_servant_busmux;

    localparam int          NS    = 3;
    localparam int          TMO   = 8;
    localparam logic [2:0]  AMASK = 3'b001;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_adr, cpu_dat;
    logic [3:0]  cpu_sel;
    logic        cpu_we, cpu_cyc;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    logic [2:0]  s_cyc;
    logic [95:0] s_rdt;
    logic [2:0]  s_ack;
    logic        err;
    logic [31:0] err_adr;
    logic        err_clr;

    logic [31:0] srdt [3];
    assign s_rdt = {srdt[2], srdt[1], srdt[0]};

    int vectors     = 0;
    int miscompares = 0;

    logic        model_err;
    logic [31:0] model_err_adr;

    always #5 clk = ~clk;

    servant_busmux #(
        .NUM_SLAVES (NS),
        .SEL_MSB    (31),
        .ACK_MASK   (AMASK),
        .TIMEOUT    (TMO),
        .ERR_DATA   (ERRD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_cpu_adr (cpu_adr),
        .i_wb_cpu_dat (cpu_dat),
        .i_wb_cpu_sel (cpu_sel),
        .i_wb_cpu_we  (cpu_we),
        .i_wb_cpu_cyc (cpu_cyc),
        .o_wb_cpu_rdt (cpu_rdt),
        .o_wb_cpu_ack (cpu_ack),
        .o_wb_s_adr   (s_adr),
        .o_wb_s_dat   (s_dat),
        .o_wb_s_sel   (s_sel),
        .o_wb_s_we    (s_we),
        .o_wb_s_cyc   (s_cyc),
        .i_wb_s_rdt   (s_rdt),
        .i_wb_s_ack   (s_ack),
        .o_err        (err),
        .o_err_adr    (err_adr),
        .i_err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave ack pattern for cycle c: slave 0 acks only at its programmed
    // delay when it is the target; every other ack line is random noise.
    function automatic logic [2:0] mk_ack(input int tgt, input int delay, input int c);
        logic [2:0] a;
        a = 3'($urandom);
        if (tgt == 0) a[0] = (c == delay);
        return a;
    endfunction

    // One master transaction, checked every cycle until the ack.
    // delay: cycle (from cyc rise) at which slave 0 acks; -1 = never.
    // clr0 : pulse i_err_clr during the request cycle.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input int delay, input logic clr0);
        int          tgt, lat;
        logic [31:0] erdt;
        logic        eerr;
        logic [2:0]  ecyc;
        tgt = int'(adr[31:30]);
        if (tgt >= NS) begin
            lat = 1; erdt = ERRD; eerr = 1'b1; ecyc = 3'b000;
        end else begin
            ecyc = 3'b001 << tgt;
            if (!AMASK[tgt]) begin
                lat = 1; erdt = we ? 32'h0 : srdt[tgt]; eerr = 1'b0;
            end else if (delay >= 0 && delay <= TMO) begin
                lat = delay + 1; erdt = we ? 32'h0 : srdt[tgt]; eerr = 1'b0;
            end else begin
                lat = TMO + 1; erdt = ERRD; eerr = 1'b1;
            end
        end
        @(posedge clk); #1;
        cpu_cyc = 1'b1; cpu_adr = adr; cpu_we = we; cpu_dat = dat; cpu_sel = sel;
        err_clr = clr0;
        s_ack   = mk_ack(tgt, delay, 0);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c == lat && eerr) begin
                model_err = 1'b1; model_err_adr = adr;
            end else if (c == 1 && clr0) begin
                model_err = 1'b0;
            end
            chk("ack", 32'(cpu_ack), 32'(c == lat));
            chk("s_cyc", 32'(s_cyc), 32'((c < lat) ? ecyc : 3'b000));
            chk("err", 32'(err), 32'(model_err));
            chk("err_adr", err_adr, model_err_adr);
            if (c == 0) begin
                chk("bcast_adr", s_adr, adr);
                chk("bcast_dat", s_dat, dat);
                chk("bcast_sel", 32'(s_sel), 32'(sel));
                chk("bcast_we", 32'(s_we), 32'(we));
            end
            if (c == lat) chk("rdt", cpu_rdt, erdt);
            @(posedge clk); #1;
            err_clr = 1'b0;
            if (c == lat) cpu_cyc = 1'b0;
            s_ack = mk_ack(tgt, delay, c + 1);
        end
        s_ack = 3'b000;
    endtask

    // Idle cycle with i_err_clr pulsed; the flag must drop afterwards.
    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        chk("err_clr", 32'(err), 32'(model_err));
    endtask

    initial begin
        rst = 1'b1; cpu_adr = 32'h0; cpu_dat = 32'h0; cpu_sel = 4'h0;
        cpu_we = 1'b0; cpu_cyc = 1'b0; s_ack = 3'b000; err_clr = 1'b0;
        srdt[0] = 32'h0; srdt[1] = 32'h0; srdt[2] = 32'h0;
        model_err = 1'b0; model_err_adr = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdt", cpu_rdt, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_adr", err_adr, 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Mux-acked read of slave 1
        srdt[1] = 32'h1234_5678;
        txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, -1, 1'b0);
        // Slave 0 acks three cycles after the request
        srdt[0] = 32'hCAFE_0001;
        txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 3, 1'b0);
        // Slave 0 acks in the request cycle and on the last legal cycle
        txn(32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 1'b0);
        txn(32'h0000_0008, 1'b0, 32'h0, 4'hF, TMO, 1'b0);
        // Timeout
        txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, -1, 1'b0);
        clear_err();
        // Unmapped region, then clear, then error and clear together
        txn(32'hC000_0000, 1'b0, 32'h0, 4'hF, -1, 1'b0);
        clear_err();
        txn(32'hC000_0004, 1'b0, 32'h0, 4'hF, -1, 1'b1);
        // Writes: mux-acked, slave-acked, and timed out
        srdt[2] = 32'h5555_AAAA;
        txn(32'h8000_0100, 1'b1, 32'hA5A5_5A5A, 4'b0110, -1, 1'b0);
        txn(32'h0000_0200, 1'b1, 32'h0F0F_F0F0, 4'b1000, 2, 1'b0);
        txn(32'h0000_0300, 1'b1, 32'h1111_2222, 4'b0001, -1, 1'b0);

        // Reset during WAIT abandons the transaction
        @(posedge clk); #1;
        cpu_cyc = 1'b1; cpu_adr = 32'h0000_0020; cpu_we = 1'b0; s_ack = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("pre_rst_s_cyc", 32'(s_cyc), 32'(3'b001));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_s_cyc", 32'(s_cyc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_cyc = 1'b0;
        model_err = 1'b0; model_err_adr = 32'h0;
        @(negedge clk);
        chk("post_rst_rdt", cpu_rdt, 32'h0);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_err_adr", err_adr, 32'h0);
        for (int c = 0; c < TMO + 2; c++) begin
            chk("post_rst_ack", 32'(cpu_ack), 32'd0);
            chk("post_rst_s_cyc", 32'(s_cyc), 32'd0);
            @(negedge clk);
        end
        srdt[0] = 32'h0BAD_F00D;
        txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 1, 1'b0);

        // Randomized traffic across all regions
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          d;
            srdt[0] = $urandom; srdt[1] = $urandom; srdt[2] = $urandom;
            a = $urandom;
            d = (a[31:30] == 2'd0) ? int'($urandom_range(0, 11)) : -1;
            txn(a, 1'($urandom), $urandom, 4'($urandom), d, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
